// File: rtl/squeeze_word_sequencer.sv
// rtl/squeeze_word_sequencer.sv - SHAKE squeeze-phase output word sequencer
//
// Walks the lanes of each rate block for a requested number of output words.
// Between blocks it asks the Keccak round controller for a permutation.
// It never asks for a permutation after the final word of a request.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start, abort        begin a squeeze (IDLE only) / return to IDLE, highest priority
//   out_len, rate       words to emit / words per rate block (0 behaves as 1)
//   perm_req, perm_ack  permutation handshake with the round controller
//   out_valid/out_ready output word stream handshake
//   word_idx            lane index within the current block
//   block_last          current word is the last lane of its block
//   out_last            current word is the last word of the request
//   busy, done          activity flag / one-cycle completion pulse
//   perm_count          (SQZ_SEQ_STATS_EN only) permutations since start, saturating
//
// Build option: define SQZ_SEQ_STATS_EN to add the perm_count statistics port.

module squeeze_word_sequencer #(
  parameter int CNT_WIDTH  = 16,
  parameter int FIRST_PERM = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] out_len,
  input  logic [CNT_WIDTH-1:0] rate,
  output logic                 perm_req,
  input  logic                 perm_ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] word_idx,
  output logic                 block_last,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
`ifdef SQZ_SEQ_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] perm_count
`endif
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PERM = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] word_idx_n;
  logic [CNT_WIDTH-1:0] remaining, remaining_n;
  logic [CNT_WIDTH-1:0] rate_q, rate_q_n;

  // All handshake outputs decode directly from the state register.
  assign perm_req   = (state == S_PERM);
  assign out_valid  = (state == S_EMIT);
  assign done       = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign block_last = out_valid && (word_idx == rate_q - ONE);
  assign out_last   = out_valid && (remaining == ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      word_idx  <= '0;
      remaining <= '0;
      rate_q    <= ONE;
    end else begin
      state     <= state_n;
      word_idx  <= word_idx_n;
      remaining <= remaining_n;
      rate_q    <= rate_q_n;
    end
  end

  always_comb begin
    state_n     = state;
    word_idx_n  = word_idx;
    remaining_n = remaining;
    rate_q_n    = rate_q;
    if (abort) begin
      state_n     = S_IDLE;
      word_idx_n  = '0;
      remaining_n = '0;
      rate_q_n    = ONE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining_n = out_len;
            rate_q_n    = (rate == '0) ? ONE : rate;
            word_idx_n  = '0;
            if (out_len == '0)
              state_n = S_DONE;
            else if (FIRST_PERM != 0)
              state_n = S_PERM;
            else
              state_n = S_EMIT;
          end
        end
        S_PERM: begin
          if (perm_ack) begin
            word_idx_n = '0;
            state_n    = S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            remaining_n = remaining - ONE;
            word_idx_n  = word_idx + ONE;
            // The final word wins over a block boundary: no trailing permutation.
            if (remaining == ONE) begin
              state_n = S_DONE;
            end else if (word_idx == rate_q - ONE) begin
              word_idx_n = '0;
              state_n    = S_PERM;
            end
          end
        end
        S_DONE: begin
          state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

`ifdef SQZ_SEQ_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perm_count <= '0;
    end else if (abort || (state == S_IDLE && start)) begin
      perm_count <= '0;
    end else if (perm_req && perm_ack && (perm_count != '1)) begin
      perm_count <= perm_count + ONE;
    end
  end
`endif

endmodule

// File: tb/tb_squeeze_word_sequencer.sv
// tb/tb_squeeze_word_sequencer.sv - self-checking bench for squeeze_word_sequencer
//
// Two instances (FIRST_PERM=0 and FIRST_PERM=1) share start/len/rate/ready.
// Each instance has its own perm_ack responder.
// Expected word sequences come from plain modular arithmetic on the request.

module tb_squeeze_word_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_len = '0;
  logic [W-1:0] rate = '0;

  logic         perm_req [2];
  logic         perm_ack [2];
  logic         out_valid [2];
  logic         block_last [2];
  logic         out_last [2];
  logic         busy [2];
  logic         done [2];
  logic [W-1:0] word_idx [2];
`ifdef SQZ_SEQ_STATS_EN
  logic [W-1:0] perm_count [2];
`endif

  always #5 clk = ~clk;

  squeeze_word_sequencer #(.CNT_WIDTH(W), .FIRST_PERM(0)) u_fp0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .out_len(out_len), .rate(rate),
    .perm_req(perm_req[0]), .perm_ack(perm_ack[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready),
    .word_idx(word_idx[0]), .block_last(block_last[0]), .out_last(out_last[0]),
    .busy(busy[0]), .done(done[0])
`ifdef SQZ_SEQ_STATS_EN
    , .perm_count(perm_count[0])
`endif
  );

  squeeze_word_sequencer #(.CNT_WIDTH(W), .FIRST_PERM(1)) u_fp1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .out_len(out_len), .rate(rate),
    .perm_req(perm_req[1]), .perm_ack(perm_ack[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready),
    .word_idx(word_idx[1]), .block_last(block_last[1]), .out_last(out_last[1]),
    .busy(busy[1]), .done(done[1])
`ifdef SQZ_SEQ_STATS_EN
    , .perm_count(perm_count[1])
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference request and observation state
  int  m_len = 0, m_rate = 1, ready_mode = 0, ack_delay = 0;
  bit  mon_en = 1'b0;
  int  cyc = 0, s_cyc = 0;
  int  k [2], perms [2], dones [2], busy_cyc [2];
  int  first_valid_cyc [2], done_cyc [2], ack_cnt [2], done_total [2];
  bit  prev_stall [2], prev_done [2];
  logic [W:0] prev_hold [2];

  function automatic int exp_perms(input int fp);
    return (m_len == 0) ? 0 : fp + (m_len - 1) / m_rate;
  endfunction

  // Input driver: out_ready pattern and per-instance perm_ack responders
  always @(posedge clk) begin
    cyc++;
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    for (int i = 0; i < 2; i++) begin
      if (perm_req[i] && !perm_ack[i]) begin
        if (ack_cnt[i] >= ack_delay) begin
          perm_ack[i] = 1'b1;
          ack_cnt[i]  = 0;
        end else begin
          ack_cnt[i]++;
        end
      end else begin
        perm_ack[i] = 1'b0;
        ack_cnt[i]  = 0;
      end
    end
  end

  // Monitor, sampled on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done[i]) done_total[i]++;
      if (mon_en) begin
        logic [W+1:0] ew;
        if (busy[i]) busy_cyc[i]++;
        if (out_valid[i] && first_valid_cyc[i] < 0) first_valid_cyc[i] = cyc;
        if (prev_stall[i]) begin
          check("stall_valid", 64'(out_valid[i]), 64'd1);
          check("stall_hold", 64'({word_idx[i], out_last[i]}), 64'(prev_hold[i]));
        end
        if (out_valid[i] && out_ready) begin
          check("word_in_bounds", 64'(k[i] < m_len), 64'd1);
          ew = {W'(k[i] % m_rate), 1'((k[i] % m_rate) == m_rate - 1), 1'(k[i] == m_len - 1)};
          check("word", 64'({word_idx[i], block_last[i], out_last[i]}), 64'(ew));
          k[i]++;
        end
        prev_stall[i] = out_valid[i] && !out_ready;
        prev_hold[i]  = {word_idx[i], out_last[i]};
        if (perm_req[i]) check("perm_past_end", 64'(k[i] < m_len), 64'd1);
        if (perm_req[i] && perm_ack[i]) begin
          check("perm_point", 64'(((k[i] % m_rate) == 0) && (k[i] > 0 || i == 1)), 64'd1);
          perms[i]++;
        end
        if (done[i]) begin
          check("done_width", 64'(prev_done[i]), 64'd0);
          dones[i]++;
          done_cyc[i] = cyc;
        end
        prev_done[i] = done[i];
      end
    end
  end

  task automatic run(input int len, input int r, input int mode, input int dly);
    out_len    = W'(len);
    rate       = W'(r);
    m_len      = len;
    m_rate     = (r == 0) ? 1 : r;
    ready_mode = mode;
    ack_delay  = dly;
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; perms[i] = 0; dones[i] = 0; busy_cyc[i] = 0;
      first_valid_cyc[i] = -1; done_cyc[i] = -1;
      prev_stall[i] = 1'b0; prev_done[i] = 1'b0;
    end
    mon_en = 1'b1;
    start  = 1'b1;
    s_cyc  = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 2000 && !(dones[0] > 0 && dones[1] > 0); t++) @(posedge clk);
    #1;
    check("completion_timeout", 64'(dones[0] > 0 && dones[1] > 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("word_count", 64'(k[i]), 64'(len));
      check("perm_handshakes", 64'(perms[i]), 64'(exp_perms(i)));
      check("done_pulses", 64'(dones[i]), 64'd1);
      check("idle_after", 64'(busy[i]), 64'd0);
`ifdef SQZ_SEQ_STATS_EN
      check("perm_count", 64'(perm_count[i]), 64'(exp_perms(i)));
`endif
      if (len == 0) begin
        check("done_latency", 64'(done_cyc[i]), 64'(s_cyc + 1));
        check("busy_cycles", 64'(busy_cyc[i]), 64'd1);
      end
    end
    if (len > 0) check("first_valid_latency", 64'(first_valid_cyc[0]), 64'(s_cyc + 1));
  endtask

  initial begin
    int d0, d1;
    perm_ack[0] = 1'b0; perm_ack[1] = 1'b0;
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    done_total[0] = 0; done_total[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("reset_outputs",
            64'({busy[i], perm_req[i], out_valid[i], done[i], block_last[i], out_last[i]}), 64'd0);
      check("reset_word_idx", 64'(word_idx[i]), 64'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(5, 3, 0, 2);
    run(5, 3, 1, 2);
    run(0, 4, 0, 1);
    run(3, 0, 0, 1);
    run(4, 4, 0, 1);

    // Abort while instance 1 waits in PERM
    @(posedge clk); #1;
    d0 = done_total[0]; d1 = done_total[1];
    out_len = W'(10); rate = W'(2); ready_mode = 0; ack_delay = 3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_pre_perm", 64'(perm_req[1]), 64'd1);
    check("abort_pre_valid", 64'(out_valid[0]), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("abort_quiet", 64'({busy[i], perm_req[i], out_valid[i]}), 64'd0);
`ifdef SQZ_SEQ_STATS_EN
      check("abort_perm_count", 64'(perm_count[i]), 64'd0);
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done0", 64'(done_total[0]), 64'(d0));
    check("abort_no_done1", 64'(done_total[1]), 64'(d1));

    // Asynchronous reset mid-operation
    d0 = done_total[0]; d1 = done_total[1];
    out_len = W'(10); rate = W'(4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_valid", 64'(out_valid[0]), 64'd1);
    check("rst_pre_perm", 64'(perm_req[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_reset", 64'({busy[i], perm_req[i], out_valid[i], done[i]}), 64'd0);
      check("async_reset_idx", 64'(word_idx[i]), 64'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_no_done0", 64'(done_total[0]), 64'(d0));
    check("rst_no_done1", 64'(done_total[1]), 64'(d1));
    run(5, 3, 0, 2);

    for (int n = 0; n < 25; n++)
      run(int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
          int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
